// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants, state encoding and counter sizing for the BCD converter
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold N_BITS itself, not just N_BITS-1.
  function automatic int cnt_width(input int n_bits);
    return $clog2(n_bits + 1);
  endfunction

  localparam int N_BITS_DEF = 8;
  localparam int CNT_W      = cnt_width(N_BITS_DEF);

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// rtl/bin2bcd_seq_ctrl_if.sv - start/busy/done handshake and operand/result bus of the BCD converter
interface bin2bcd_seq_ctrl_if
  import bin2bcd_pkg::*;
#(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
);

  logic                          start;
  logic [N_BITS-1:0]             bin_in;
  logic                          busy;
  logic                          done;
  logic [DIGIT_W*N_DIGITS-1:0]   bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out
  );

endinterface

// File: rtl/bin2bcd_seq_ctrl_add3.sv
// rtl/bin2bcd_seq_ctrl_add3.sv - double-dabble digit correction cell (+3 when digit >= 5)
module Add3_if_gte5
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // Inputs never exceed 9, so the 4-bit sum never wraps.
  assign o_digit = (i_digit >= DIGIT_W'(5)) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// rtl/bin2bcd_seq_ctrl.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
)(
  input  logic               clk,
  input  logic               rst,
  bin2bcd_seq_ctrl_if.slave  bus
);

  localparam int C_W   = cnt_width(N_BITS);
  localparam int BCD_W = DIGIT_W * N_DIGITS;

  if (10**N_DIGITS <= 2**N_BITS - 1) begin : g_param_err
    $error("bin2bcd_seq_ctrl: N_DIGITS too small for N_BITS");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_W-1:0]      r_cnt;
  logic [N_BITS-1:0]   r_bin_sr;
  logic [BCD_W-1:0]    r_bcd_sr;
  logic [BCD_W-1:0]    r_bcd_out;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_last;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W+N_BITS-1:0] w_shl;
  logic [BCD_W-1:0]    w_bcd_nxt;
  logic [N_BITS-1:0]   w_bin_nxt;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    Add3_if_gte5 u_add3 (
      .i_digit (r_bcd_sr[DIGIT_W*k +: DIGIT_W]),
      .o_digit (w_bcd_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The bit shifted out of the top digit is always 0 for legal parameters.
  assign w_shl     = {w_bcd_adj, r_bin_sr} << 1;
  assign w_bcd_nxt = w_shl[BCD_W+N_BITS-1:N_BITS];
  assign w_bin_nxt = w_shl[N_BITS-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == C_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bin_sr  <= '0;
      r_bcd_sr  <= '0;
      r_bcd_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_accept) begin
        r_bin_sr <= bus.bin_in;
        r_bcd_sr <= '0;
        r_cnt    <= C_W'(N_BITS);
        r_busy   <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_bin_sr <= w_bin_nxt;
        r_bcd_sr <= w_bcd_nxt;
        r_cnt    <= r_cnt - C_W'(1);
        if (w_last) begin
          r_busy    <= 1'b0;
          r_bcd_out <= w_bcd_nxt;
        end
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd_out;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb/tb_bin2bcd_seq_ctrl.sv - self-checking bench for 8-bit/3-digit and 16-bit/5-digit converters
module tb_bin2bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_ctrl_if #(.N_BITS(8),  .N_DIGITS(3)) bus8  ();
  bin2bcd_seq_ctrl_if #(.N_BITS(16), .N_DIGITS(5)) bus16 ();

  bin2bcd_seq_ctrl #(.N_BITS(8),  .N_DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  bin2bcd_seq_ctrl #(.N_BITS(16), .N_DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic longint to_bcd(input longint v, input int nd);
    longint r = 0;
    longint p = 1;
    for (int k = 0; k < nd; k++) begin
      r = r | (((v / p) % 10) << (4 * k));
      p = p * 10;
    end
    return r;
  endfunction

  typedef struct {
    bit     busy;
    bit     done;
    int     cnt;
    longint opnd;
    longint bcd;
  } m_t;

  localparam m_t M_RST = '{busy: 1'b0, done: 1'b0, cnt: 0, opnd: 0, bcd: 0};

  // One clock of the converter: accept when idle, finish N_BITS clocks later.
  function automatic m_t step(input m_t m, input bit st, input longint bin, input int nb, input int nd);
    m_t n = m;
    n.done = 1'b0;
    if (m.busy) begin
      n.cnt = m.cnt - 1;
      if (n.cnt == 0) begin
        n.busy = 1'b0;
        n.done = 1'b1;
        n.bcd  = to_bcd(m.opnd, nd);
      end
    end else if (st) begin
      n.busy = 1'b1;
      n.cnt  = nb;
      n.opnd = bin;
    end
    return n;
  endfunction

  m_t m8  = M_RST;
  m_t m16 = M_RST;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8  <= M_RST;
      m16 <= M_RST;
    end else begin
      m8  <= step(m8,  bus8.start  === 1'b1, longint'(bus8.bin_in),  8,  3);
      m16 <= step(m16, bus16.start === 1'b1, longint'(bus16.bin_in), 16, 5);
    end
  end

  always @(negedge clk) begin
    chk("busy8",  32'(bus8.busy),     32'(m8.busy));
    chk("done8",  32'(bus8.done),     32'(m8.done));
    chk("bcd8",   32'(bus8.bcd_out),  32'(m8.bcd));
    chk("busy16", 32'(bus16.busy),    32'(m16.busy));
    chk("done16", 32'(bus16.done),    32'(m16.done));
    chk("bcd16",  32'(bus16.bcd_out), 32'(m16.bcd));
  end

  task automatic drive(input bit wide, input bit s, input logic [31:0] v);
    if (wide) begin
      bus16.start  = s;
      bus16.bin_in = v[15:0];
    end else begin
      bus8.start  = s;
      bus8.bin_in = v[7:0];
    end
  endtask

  function automatic logic rd_busy(input bit wide);
    return wide ? bus16.busy : bus8.busy;
  endfunction

  function automatic logic rd_done(input bit wide);
    return wide ? bus16.done : bus8.done;
  endfunction

  function automatic logic [31:0] rd_bcd(input bit wide);
    return wide ? 32'(bus16.bcd_out) : 32'(bus8.bcd_out);
  endfunction

  // Called right after a negedge; returns at the negedge of the done cycle.
  task automatic conv(input bit wide, input logic [31:0] v, input logic [31:0] exp,
                      input logic [31:0] prev, input int inject);
    int n    = 0;
    int nb   = 0;
    int bits = wide ? 16 : 8;
    drive(wide, 1'b1, v);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) drive(wide, 1'b0, v);
      if (inject > 0 && n == inject) drive(wide, 1'b1, 32'd7);
      if (inject > 0 && n == inject + 1) drive(wide, 1'b0, 32'd7);
      if (rd_busy(wide)) nb++;
      if (n == 4) chk("hold_prev", rd_bcd(wide), prev);
    end while (!rd_done(wide) && n < 40);
    chk("latency",  32'(n),  32'(bits + 1));
    chk("busy_len", 32'(nb), 32'(bits));
    chk("result",   rd_bcd(wide), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dones;
    logic [31:0] v;
    logic [31:0] prev16;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy),    32'd0);
    chk("rst_done", 32'(bus8.done),    32'd0);
    chk("rst_bcd",  32'(bus8.bcd_out), 32'd0);
    chk("rst_bcd16", 32'(bus16.bcd_out), 32'd0);
    chk("pin_255",   32'(to_bcd(255, 3)),   32'h255);
    chk("pin_65535", 32'(to_bcd(65535, 5)), 32'h65535);
    rst = 1'b0;
    @(negedge clk);

    conv(1'b0, 32'd0,   32'h000, 32'h000, 0);
    conv(1'b0, 32'd255, 32'h255, 32'h000, 0);
    conv(1'b0, 32'd99,  32'h099, 32'h255, 0);
    conv(1'b0, 32'd100, 32'h100, 32'h099, 0);

    conv(1'b0, 32'd123, 32'h123, 32'h100, 4);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    chk("single_done", 32'(dones), 32'd0);
    chk("ignored_val", 32'(bus8.bcd_out), 32'h123);

    conv(1'b0, 32'd255, 32'h255, 32'h123, 0);
    conv(1'b0, 32'd42,  32'h042, 32'h255, 0);
    @(negedge clk);
    chk("done_width", 32'(bus8.done), 32'd0);

    drive(1'b0, 1'b1, 32'd200);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd200);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus8.busy),    32'd0);
    chk("abort_done", 32'(bus8.done),    32'd0);
    chk("abort_bcd",  32'(bus8.bcd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    conv(1'b0, 32'd13, 32'h013, 32'h000, 0);

    conv(1'b1, 32'd65535, 32'h65535, 32'h00000, 0);
    conv(1'b1, 32'd0,     32'h00000, 32'h65535, 0);
    conv(1'b1, 32'd9999,  32'h09999, 32'h00000, 0);
    prev16 = 32'h09999;
    for (int i = 0; i < 16; i++) begin
      v = 32'($urandom_range(0, 65535));
      conv(1'b1, v, 32'(to_bcd(longint'(v), 5)), prev16, 0);
      prev16 = 32'(to_bcd(longint'(v), 5));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
